// File: rtl/sim_host_ctrl.sv
// -----------------------------------------------------------------------------
// sim_host_ctrl
//   Host-side run sequencer for the DART network simulator top. One run is:
//   hold the simulator in reset, forward a fixed number of host config words,
//   enable the simulator for run_length sim-time ticks, wait for the network to
//   drain (with a watchdog), then read the stats shift chain back to the host
//   one word at a time.
//
// Ports
//   clock, reset                 system clock, asynchronous active-high reset
//   start, run_length            run request (IDLE only) and tick budget
//   host_cmd_valid/ready/data    config word stream from the host
//   host_resp_valid/ready/data   stats word stream to the host
//   sim_reset, sim_enable        simulator reset / enable
//   sim_config_in(_valid)        config word and one-cycle strobe to the simulator
//   sim_stats_shift              one-cycle pulse advancing the stats chain
//   sim_stats_out                current head word of the stats chain
//   sim_time_tick                one pulse per simulator time step
//   sim_quiescent, sim_error     network empty / simulator error
//   busy, done, err              run in progress / run complete / sticky error
// -----------------------------------------------------------------------------
module sim_host_ctrl #(
  parameter int CONFIG_WORDS    = 64,
  parameter int STATS_WORDS     = 128,
  parameter int TS_WIDTH        = 10,
  parameter int RST_CYCLES      = 4,
  parameter int QUIESCE_TIMEOUT = 4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [TS_WIDTH-1:0] run_length,
  input  logic                host_cmd_valid,
  output logic                host_cmd_ready,
  input  logic [15:0]         host_cmd_data,
  output logic                host_resp_valid,
  input  logic                host_resp_ready,
  output logic [15:0]         host_resp_data,
  output logic                sim_reset,
  output logic                sim_enable,
  output logic [15:0]         sim_config_in,
  output logic                sim_config_in_valid,
  output logic                sim_stats_shift,
  input  logic [15:0]         sim_stats_out,
  input  logic                sim_time_tick,
  input  logic                sim_quiescent,
  input  logic                sim_error,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int CC_W = $clog2(CONFIG_WORDS + 1);
  localparam int SC_W = $clog2(STATS_WORDS + 1);
  localparam int WD_W = $clog2(QUIESCE_TIMEOUT + 1);

  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CC_W-1:0] CFG_LAST = CC_W'(CONFIG_WORDS - 1);
  localparam logic [SC_W-1:0] ST_LAST  = SC_W'(STATS_WORDS - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(QUIESCE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIMRST,
    S_CONFIG,
    S_RUN,
    S_WAIT_Q,
    S_SLOAD,
    S_SHOLD,
    S_SWAIT
  } state_t;

  state_t              state_q, state_d;
  logic [TS_WIDTH-1:0] rl_q, rl_d;
  logic [TS_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CC_W-1:0]     cfg_cnt_q, cfg_cnt_d;
  logic [SC_W-1:0]     st_cnt_q, st_cnt_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [15:0]         resp_data_q, resp_data_d;
  logic                sim_reset_q, sim_reset_d;
  logic                sim_enable_q, sim_enable_d;
  logic [15:0]         cfg_data_q, cfg_data_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [TS_WIDTH-1:0] tick_inc;

  assign tick_inc = tick_cnt_q + TS_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    rl_d         = rl_q;
    tick_cnt_d   = tick_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    cfg_cnt_d    = cfg_cnt_q;
    st_cnt_d     = st_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    cfg_data_d   = cfg_data_q;
    cfg_valid_d  = 1'b0;
    shift_d      = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rl_d      = run_length;
          done_d    = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          rst_cnt_d = '0;
          state_d   = S_SIMRST;
        end
      end

      S_SIMRST: begin
        if (rst_cnt_q == RST_LAST) begin
          cfg_cnt_d = '0;
          state_d   = S_CONFIG;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end

      S_CONFIG: begin
        // Ready is a flop, so it only drops on the edge that takes the last
        // word; no extra word can slip in behind it.
        if (host_cmd_valid && cmd_ready_q) begin
          cfg_data_d  = host_cmd_data;
          cfg_valid_d = 1'b1;
          cfg_cnt_d   = cfg_cnt_q + CC_W'(1);
          if (cfg_cnt_q == CFG_LAST) begin
            tick_cnt_d = '0;
            wd_cnt_d   = '0;
            state_d    = (rl_q == '0) ? S_WAIT_Q : S_RUN;
          end
        end
      end

      S_RUN: begin
        // Counter stops at the match, so it cannot wrap even for the
        // largest run_length.
        if (sim_time_tick) begin
          tick_cnt_d = tick_inc;
          if (tick_inc == rl_q) begin
            wd_cnt_d = '0;
            state_d  = S_WAIT_Q;
          end
        end
      end

      S_WAIT_Q: begin
        if (sim_quiescent) begin
          st_cnt_d = '0;
          state_d  = S_SLOAD;
        end else if (wd_cnt_q == WD_LAST) begin
          err_d    = 1'b1;
          st_cnt_d = '0;
          state_d  = S_SLOAD;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end

      S_SLOAD: begin
        resp_data_d  = sim_stats_out;
        resp_valid_d = 1'b1;
        state_d      = S_SHOLD;
      end

      S_SHOLD: begin
        if (host_resp_ready) begin
          resp_valid_d = 1'b0;
          shift_d      = 1'b1;
          st_cnt_d     = st_cnt_q + SC_W'(1);
          if (st_cnt_q == ST_LAST) begin
            // Run completes here: done rises as the FSM lands back in IDLE.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SWAIT;
          end
        end
      end

      // One idle cycle so the chain head settles after the shift pulse.
      S_SWAIT: state_d = S_SLOAD;

      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && sim_error) begin
      err_d = 1'b1;
    end
  end

  // Level outputs are registered from the next state so they change exactly
  // on the state transition edge.
  always_comb begin
    cmd_ready_d  = (state_d == S_CONFIG);
    sim_reset_d  = (state_d == S_SIMRST);
    sim_enable_d = (state_d == S_RUN) || (state_d == S_WAIT_Q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rl_q         <= '0;
      tick_cnt_q   <= '0;
      rst_cnt_q    <= '0;
      cfg_cnt_q    <= '0;
      st_cnt_q     <= '0;
      wd_cnt_q     <= '0;
      cmd_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      sim_reset_q  <= 1'b0;
      sim_enable_q <= 1'b0;
      cfg_data_q   <= '0;
      cfg_valid_q  <= 1'b0;
      shift_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rl_q         <= rl_d;
      tick_cnt_q   <= tick_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      cfg_cnt_q    <= cfg_cnt_d;
      st_cnt_q     <= st_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      sim_reset_q  <= sim_reset_d;
      sim_enable_q <= sim_enable_d;
      cfg_data_q   <= cfg_data_d;
      cfg_valid_q  <= cfg_valid_d;
      shift_q      <= shift_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign host_cmd_ready      = cmd_ready_q;
  assign host_resp_valid     = resp_valid_q;
  assign host_resp_data      = resp_data_q;
  assign sim_reset           = sim_reset_q;
  assign sim_enable          = sim_enable_q;
  assign sim_config_in       = cfg_data_q;
  assign sim_config_in_valid = cfg_valid_q;
  assign sim_stats_shift     = shift_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_sim_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_host_ctrl
//   Scoreboard bench for sim_host_ctrl with a small simulator model (tick
//   generator, stats chain). Stimulus pushes expected config words, stats
//   words and end-of-run observations into queues; one monitor process on the
//   falling edge pops and compares them against what the DUT presents.
// -----------------------------------------------------------------------------
module tb_sim_host_ctrl;

  localparam int CW = 4;
  localparam int SW = 3;
  localparam int TW = 10;
  localparam int RC = 4;
  localparam int QT = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [TW-1:0] run_length = '0;
  logic          host_cmd_valid = 1'b0;
  logic          host_cmd_ready;
  logic [15:0]   host_cmd_data = '0;
  logic          host_resp_valid;
  logic          host_resp_ready = 1'b0;
  logic [15:0]   host_resp_data;
  logic          sim_reset;
  logic          sim_enable;
  logic [15:0]   sim_config_in;
  logic          sim_config_in_valid;
  logic          sim_stats_shift;
  logic [15:0]   sim_stats_out;
  logic          sim_time_tick;
  logic          sim_quiescent = 1'b1;
  logic          sim_error = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  sim_host_ctrl #(
    .CONFIG_WORDS(CW), .STATS_WORDS(SW), .TS_WIDTH(TW),
    .RST_CYCLES(RC), .QUIESCE_TIMEOUT(QT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .run_length(run_length),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd_data(host_cmd_data), .host_resp_valid(host_resp_valid),
    .host_resp_ready(host_resp_ready), .host_resp_data(host_resp_data),
    .sim_reset(sim_reset), .sim_enable(sim_enable), .sim_config_in(sim_config_in),
    .sim_config_in_valid(sim_config_in_valid), .sim_stats_shift(sim_stats_shift),
    .sim_stats_out(sim_stats_out), .sim_time_tick(sim_time_tick),
    .sim_quiescent(sim_quiescent), .sim_error(sim_error),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Simulator model: a tick every third cycle and a 3-word stats chain.
  logic [1:0]  tick_ph = 2'd0;
  logic [15:0] chain [0:3];
  logic [1:0]  idx = 2'd0;

  always @(posedge clock) tick_ph <= (tick_ph == 2'd2) ? 2'd0 : tick_ph + 2'd1;
  assign sim_time_tick = (tick_ph == 2'd2);

  always @(posedge clock) begin
    if (sim_reset) idx <= 2'd0;
    else if (sim_stats_shift && idx != 2'd3) idx <= idx + 2'd1;
  end
  assign sim_stats_out = chain[idx];

  // Scoreboard queues
  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  chk_t        chk_q [$];
  logic [15:0] cfg_q [$];
  logic [15:0] stat_q [$];

  int checks = 0;
  int errors = 0;

  // Monitor-owned observation counters (cumulative)
  int n_rst = 0, n_en = 0, n_tick = 0, n_shift = 0;
  int rx_total = 0, stall_cnt = 0;
  logic [15:0] hold_data = '0;

  // Stimulus-owned stall request: stall the word whose global index is stall_at
  int stall_at = -1;
  int stall_len = 0;

  always @(negedge clock) begin
    chk_t        c;
    logic [15:0] e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0h want %0h", c.name, c.act, c.exp);
      end
    end

    if (sim_config_in_valid) begin
      checks++;
      if (cfg_q.size() == 0) begin
        errors++;
        $display("FAIL cfg_unexpected: got %h want no strobe", sim_config_in);
      end else begin
        e = cfg_q.pop_front();
        if (sim_config_in !== e) begin
          errors++;
          $display("FAIL cfg_word: got %h want %h", sim_config_in, e);
        end
      end
    end

    if (host_resp_valid) begin
      if (rx_total == stall_at && stall_cnt < stall_len) begin
        if (stall_cnt > 0) begin
          checks++;
          if (host_resp_data !== hold_data) begin
            errors++;
            $display("FAIL resp_stable: got %h want %h", host_resp_data, hold_data);
          end
        end
        hold_data = host_resp_data;
        stall_cnt++;
        host_resp_ready = 1'b0;
      end else begin
        checks++;
        if (stat_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got %h want no word", host_resp_data);
        end else begin
          e = stat_q.pop_front();
          if (host_resp_data !== e) begin
            errors++;
            $display("FAIL resp_word: got %h want %h", host_resp_data, e);
          end
        end
        host_resp_ready = 1'b1;
        rx_total++;
        stall_cnt = 0;
      end
    end else begin
      host_resp_ready = 1'b0;
    end

    if (sim_reset) n_rst++;
    if (sim_enable) n_en++;
    if (sim_enable && sim_time_tick) n_tick++;
    if (sim_stats_shift) n_shift++;
  end

  task automatic post(input string n, input logic [63:0] a, input logic [63:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic do_start(input logic [TW-1:0] rl);
    @(posedge clock); #1;
    run_length = rl;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [15:0] seed, input bit gap);
    logic [15:0] w;
    bit          ok;
    for (int i = 0; i < n; i++) begin
      w = seed + 16'(i) * 16'h1111;
      cfg_q.push_back(w);
      host_cmd_data  = w;
      host_cmd_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clock);
        if (host_cmd_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        post("cfg_ready_timeout", 64'd0, 64'd1);
        host_cmd_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
      host_cmd_valid = 1'b0;
      if (gap && (i % 2 == 0)) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic load_chain(input logic [15:0] base);
    for (int i = 0; i < SW; i++) begin
      chain[i] = base + 16'(i);
      stat_q.push_back(base + 16'(i));
    end
    chain[3] = 16'hEEEE;
  endtask

  task automatic wait_done(input string n);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (done && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    post(n, 64'(ok), 64'd1);
    @(posedge clock);
    @(negedge clock); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b_rst, b_en, b_tick, b_shift;

    for (int i = 0; i < 4; i++) chain[i] = 16'h0;

    // Reset state
    @(posedge clock); #1;
    post("reset_outputs", 64'({host_cmd_ready, host_resp_valid, host_resp_data, sim_reset,
         sim_enable, sim_config_in, sim_config_in_valid, sim_stats_shift, busy, done, err}), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Run A: four config words with valid toggling, run_length=5
    b_rst = n_rst; b_tick = n_tick; b_shift = n_shift;
    load_chain(16'h00A0);
    do_start(10'd5);
    post("busy_after_start", 64'(busy), 64'd1);
    send_words(CW, 16'h1111, 1'b1);
    host_cmd_data = 16'hDEAD;
    host_cmd_valid = 1'b1;
    repeat (4) @(posedge clock);
    #1 host_cmd_valid = 1'b0;
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done("runA_done");
    post("runA_rst_cycles", 64'(n_rst - b_rst), 64'(RC));
    post("runA_enabled_ticks", 64'(n_tick - b_tick), 64'd5);
    post("runA_shifts", 64'(n_shift - b_shift), 64'(SW));
    post("runA_err", 64'(err), 64'd0);
    post("runA_busy", 64'(busy), 64'd0);
    post("runA_cfg_drained", 64'(cfg_q.size()), 64'd0);
    post("runA_stats_drained", 64'(stat_q.size()), 64'd0);

    // Run B: run_length=0, enable only for the single WAIT_Q cycle
    b_en = n_en;
    load_chain(16'h00B0);
    do_start(10'd0);
    send_words(CW, 16'h0102, 1'b0);
    wait_done("runB_done");
    post("runB_enable_cycles", 64'(n_en - b_en), 64'd1);
    post("runB_err", 64'(err), 64'd0);
    post("runB_stats_drained", 64'(stat_q.size()), 64'd0);

    // Run C: host stalls word 2 for five cycles; sim_error pulse during SIMRST
    b_shift = n_shift;
    stall_at = rx_total + 1;
    stall_len = 5;
    load_chain(16'h00C0);
    do_start(10'd2);
    sim_error = 1'b1;
    @(posedge clock); #1 sim_error = 1'b0;
    send_words(CW, 16'h2468, 1'b1);
    wait_done("runC_done");
    post("runC_shifts", 64'(n_shift - b_shift), 64'(SW));
    post("runC_err_sticky", 64'(err), 64'd1);
    post("runC_stats_drained", 64'(stat_q.size()), 64'd0);
    stall_at = -1;

    // Run D: quiescent stuck low, watchdog forces the drain
    b_en = n_en; b_shift = n_shift;
    sim_quiescent = 1'b0;
    load_chain(16'h00D0);
    do_start(10'd0);
    post("runD_err_cleared", 64'(err), 64'd0);
    send_words(CW, 16'h3000, 1'b0);
    wait_done("runD_done");
    post("runD_enable_cycles", 64'(n_en - b_en), 64'(QT));
    post("runD_err", 64'(err), 64'd1);
    post("runD_shifts", 64'(n_shift - b_shift), 64'(SW));
    sim_quiescent = 1'b1;

    // Run E: reset after two config words, then a full rerun
    do_start(10'd3);
    send_words(2, 16'h5000, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    post("midrun_reset_outputs", 64'({host_cmd_ready, host_resp_valid, host_resp_data, sim_reset,
         sim_enable, sim_config_in, sim_config_in_valid, sim_stats_shift, busy, done, err}), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    post("midrun_cfg_drained", 64'(cfg_q.size()), 64'd0);

    b_rst = n_rst; b_shift = n_shift;
    load_chain(16'h00E0);
    do_start(10'd1);
    send_words(CW, 16'h6000, 1'b1);
    wait_done("runE_done");
    post("runE_rst_cycles", 64'(n_rst - b_rst), 64'(RC));
    post("runE_shifts", 64'(n_shift - b_shift), 64'(SW));
    post("runE_err", 64'(err), 64'd0);
    post("runE_cfg_drained", 64'(cfg_q.size()), 64'd0);
    post("runE_stats_drained", 64'(stat_q.size()), 64'd0);

    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
